console_rx_mbox: RTL and testbench
==================================

CONSOLE_RX_MBOX -- requirements
Module: console_rx_mbox

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h01ff_ffe0, base of the 16-byte register window; must be 16-byte aligned.
REQ-002 SHALL have parameter DEPTH, default 16, character FIFO entries; power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port host_chr_vld  input  1  host offers a character.
REQ-006 SHALL have port host_chr  input  8  offered character.
REQ-007 SHALL have port host_chr_rdy  output  1  character accepted this cycle when high with host_chr_vld.
REQ-008 SHALL have port req_vld  input  1  CPU-side register request valid.
REQ-009 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  128  write data, 32-bit lane selected by req_addr[3:2].
REQ-012 SHALL have port req_wstrb  input  16  byte strobes; lane write effective only if all 4 strobes of that lane are set.
REQ-013 SHALL have port req_rdy  output  1  request accepted when high with req_vld.
REQ-014 SHALL have port rsp_vld  output  1  one-cycle response pulse.
REQ-015 SHALL have port rsp_rdata  output  128  read data, 32-bit value in lane req_addr[3:2], other lanes zero.
REQ-016 SHALL have port irq  output  1  level interrupt: FIFO non-empty and enabled.

Function
REQ-017 Registers at offsets: 0x0 DATA (read pops), 0x4 STATUS (read-only), 0x8 CTRL (read/write), 0xC reads zero.
REQ-018 DATA read: bit31 = valid, [7:0] = head character; empty FIFO returns 0 with no state change.
REQ-019 STATUS: [8:0] = entry count, bit16 = empty, bit17 = full, bit18 = overflow sticky.
REQ-020 CTRL: bit0 flush (write-1, self-clearing, reads 0), bit1 clear overflow (write-1, reads 0), bit2 irq enable (stored).
REQ-021 Request FSM: IDLE, RESP; req_rdy = 1 only in IDLE; accepted request -> RESP next cycle with rsp_vld = 1; RESP -> IDLE unconditionally; latency exactly 1 cycle, throughput 1 request per 2 cycles.
REQ-022 Writes and addresses outside [BASE_ADDR, BASE_ADDR+15] produce rsp_vld with rsp_rdata = 0; out-of-window requests have no side effect.
REQ-023 host_chr_rdy = not full; push occurs on host_chr_vld & host_chr_rdy.
REQ-024 host_chr_vld while full sets overflow; character dropped.
REQ-025 Simultaneous push and pop: both occur, count unchanged; on a full FIFO the pop does not enable a same-cycle push.
REQ-026 Flush in the same cycle as push or pop: flush wins, FIFO empty next cycle, pushed character discarded.
REQ-027 Clear-overflow in the same cycle as a new overflow event: overflow remains set.
REQ-028 Pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
REQ-029 irq registered: irq = irq_en & ~empty, updated one cycle after the state change.

Reset
REQ-030 rst_b low asynchronously: FIFO empty, pointers 0, overflow 0, irq_en 0, FSM IDLE, rsp_vld 0, rsp_rdata 0, irq 0, host_chr_rdy 1 after release.
REQ-031 rst_b asserted during RESP: response discarded, rsp_vld 0, no pop completes.

Configuration
REQ-032 Macro CONSOLE_RX_MBOX_ECHO_EN defined: outputs echo_vld (1) and echo_chr (8) exist; each valid DATA pop drives echo_vld = 1 for one cycle with echo_chr = popped character, aligned with rsp_vld; reset value 0.
REQ-033 Macro undefined: echo ports and logic absent; all other behaviour identical.

Verification
REQ-034 Push 'A','B','C'; read BASE+0x4 -> count 3; read BASE+0x0 three times -> 0x8000_0041, 0x8000_0042, 0x8000_0043; fourth read -> 0.
REQ-035 Push 17 characters with DEPTH=16 -> host_chr_rdy low after 16th, STATUS = 0x0006_0010 (full, overflow, count 16); write CTRL 0x2 -> overflow 0.
REQ-036 Read BASE+0x4 with addr[3:2]=01 -> value in rsp_rdata[63:32], other lanes 0, rsp_vld exactly one cycle after acceptance, req_rdy low in that cycle.
REQ-037 Write CTRL 0x4, push one char -> irq 1 one cycle after push; pop -> irq 0 one cycle after pop.
REQ-038 Write CTRL 0x1 in the same cycle as a push into 5-entry FIFO -> STATUS = 0x0001_0000.
REQ-039 Assert rst_b low mid-traffic for 1 cycle -> all outputs at reset values immediately; with CONSOLE_RX_MBOX_ECHO_EN, popping 'Z' gives echo_vld pulse with echo_chr 0x5A.

Source files
------------

// File: rtl/console_rx_mbox.sv
// console_rx_mbox
//   Receive mailbox for a console character stream. The host side pushes
//   characters into a small FIFO. The CPU side reads them through a 16-byte
//   register window at BASE_ADDR.
//
//   Register map (byte offset from BASE_ADDR; each register is a 32-bit lane):
//     0x0 DATA   read pops: bit31 = valid, [7:0] = head character
//     0x4 STATUS [8:0] count, bit16 empty, bit17 full, bit18 overflow (sticky)
//     0x8 CTRL   bit0 flush (W1, reads 0), bit1 clear overflow (W1, reads 0),
//                bit2 irq enable (stored)
//     0xC        reads zero
//
//   Ports:
//     clk, rst_b               clock, asynchronous active-low reset
//     host_chr_vld/host_chr    character offered by the host
//     host_chr_rdy             FIFO not full
//     req_vld/req_wr/req_addr  CPU request (read or write)
//     req_wdata/req_wstrb      128-bit write data and byte strobes
//     req_rdy                  high while the request FSM is idle
//     rsp_vld/rsp_rdata        one-cycle response, value placed in lane addr[3:2]
//     irq                      registered irq_en & FIFO non-empty
//
//   Optional feature (macro CONSOLE_RX_MBOX_ECHO_EN):
//     echo_vld/echo_chr        pulse carrying each popped character, aligned
//                              with rsp_vld
module console_rx_mbox #(
  parameter logic [31:0] BASE_ADDR = 32'h01ff_ffe0,
  parameter int          DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         host_chr_vld,
  input  logic [7:0]   host_chr,
  output logic         host_chr_rdy,
  input  logic         req_vld,
  input  logic         req_wr,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wstrb,
  output logic         req_rdy,
  output logic         rsp_vld,
  output logic [127:0] rsp_rdata,
  output logic         irq
`ifdef CONSOLE_RX_MBOX_ECHO_EN
  ,
  output logic         echo_vld,
  output logic [7:0]   echo_chr
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q, irq_en_q;
  logic [127:0]  rsp_rdata_q, rsp_rdata_d;
  logic [31:0]   reg_val, status;
  logic [1:0]    lane;
  logic          empty, full, accept, in_win;
  logic          do_push, do_pop, ctrl_wr, flush, clr_ovf, ovf_set;

  // Only the CTRL lane payload bits and the lane-2 strobes are meaningful.
  logic unused_bits;
  assign unused_bits = ^{req_wdata[127:67], req_wdata[63:0],
                         req_wstrb[15:12], req_wstrb[7:0], req_addr[1:0]};

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign host_chr_rdy = ~full;
  assign lane         = req_addr[3:2];
  assign in_win       = (req_addr[31:4] == BASE_ADDR[31:4]);
  assign accept       = req_vld & req_rdy;

  // A push is decided on the registered full flag. A pop in the same
  // cycle therefore never makes room for a push into a full FIFO.
  assign do_push = host_chr_vld & ~full;
  assign ovf_set = host_chr_vld & full;
  assign do_pop  = accept & ~req_wr & in_win & (lane == 2'd0) & ~empty;
  assign ctrl_wr = accept & req_wr & in_win & (lane == 2'd2) & (&req_wstrb[11:8]);
  assign flush   = ctrl_wr & req_wdata[64];
  assign clr_ovf = ctrl_wr & req_wdata[65];

  // Request FSM: IDLE accepts, RESP presents the registered response.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req_rdy = 1'b0;
    rsp_vld = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_d = RESP;
      end
      RESP: begin
        rsp_vld = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status        = '0;
    status[8:0]   = 9'(count_q);
    status[16]    = empty;
    status[17]    = full;
    status[18]    = ovf_q;
  end

  // Read value for the addressed register, then steered into its lane.
  // Writes and out-of-window requests answer with all zeros.
  always_comb begin
    reg_val = '0;
    unique case (lane)
      2'd0:    reg_val = empty ? 32'h0 : {1'b1, 23'h0, mem[rd_ptr_q]};
      2'd1:    reg_val = status;
      2'd2:    reg_val = {29'h0, irq_en_q, 2'b00};
      default: reg_val = '0;
    endcase
    rsp_rdata_d = '0;
    if (!req_wr && in_win) begin
      unique case (lane)
        2'd0:    rsp_rdata_d[31:0]   = reg_val;
        2'd1:    rsp_rdata_d[63:32]  = reg_val;
        2'd2:    rsp_rdata_d[95:64]  = reg_val;
        default: rsp_rdata_d[127:96] = reg_val;
      endcase
    end
  end

  // Storage has no reset. Validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= host_chr;
  end

  // FIFO pointers and count. A flush overrides any push or pop in the same
  // cycle. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A new overflow event beats a same-cycle clear. irq follows the
  // registered state, so it trails a FIFO change by one cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~clr_ovf);
      if (ctrl_wr) irq_en_q <= req_wdata[66];
      irq <= irq_en_q & ~empty;
    end
  end

  // Response data is captured at acceptance and is zero outside RESP.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) rsp_rdata_q <= '0;
    else        rsp_rdata_q <= accept ? rsp_rdata_d : '0;
  end

  assign rsp_rdata = rsp_rdata_q;

`ifdef CONSOLE_RX_MBOX_ECHO_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      echo_vld <= 1'b0;
      echo_chr <= '0;
    end else begin
      echo_vld <= do_pop;
      echo_chr <= do_pop ? mem[rd_ptr_q] : 8'h00;
    end
  end
`endif

endmodule

// File: tb/tb_console_rx_mbox.sv
// tb_console_rx_mbox
//   Directed bench for console_rx_mbox (default parameters).
//   Requests queue their expected response in a scoreboard. A monitor
//   on the falling edge compares each rsp_vld beat against the queue head.
module tb_console_rx_mbox;

  localparam logic [31:0] BASE = 32'h01ff_ffe0;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_RSVD = BASE + 32'hC;

  logic         clk = 1'b0;
  logic         rst_b;
  logic         host_chr_vld;
  logic [7:0]   host_chr;
  logic         host_chr_rdy;
  logic         req_vld;
  logic         req_wr;
  logic [31:0]  req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic         req_rdy;
  logic         rsp_vld;
  logic [127:0] rsp_rdata;
  logic         irq;
`ifdef CONSOLE_RX_MBOX_ECHO_EN
  logic         echo_vld;
  logic [7:0]   echo_chr;
`endif

  int tests = 0;
  int fails = 0;
  logic [127:0] sb[$];

  console_rx_mbox dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .host_chr_vld (host_chr_vld),
    .host_chr     (host_chr),
    .host_chr_rdy (host_chr_rdy),
    .req_vld      (req_vld),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_rdy      (req_rdy),
    .rsp_vld      (rsp_vld),
    .rsp_rdata    (rsp_rdata),
    .irq          (irq)
`ifdef CONSOLE_RX_MBOX_ECHO_EN
    ,
    .echo_vld     (echo_vld),
    .echo_chr     (echo_chr)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request (optionally with a same-cycle host push) and queue
  // the expected response. Returns one cycle after the response cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] lane_strb,
                               input logic [31:0] exp_val,
                               input logic push_en, input logic [7:0] push_c);
    logic [127:0] exp128;
    int waited;
    waited = 0;
    while (!req_rdy && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!req_rdy) begin
      tests++;
      fails++;
      $display("[TB] FAIL req_rdy_timeout: got 0 expected 1");
    end
    req_vld   = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = '0;
    req_wstrb = '0;
    exp128    = '0;
    unique case (addr[3:2])
      2'd0: begin req_wdata[31:0]   = wdata; req_wstrb[3:0]   = lane_strb; exp128[31:0]   = exp_val; end
      2'd1: begin req_wdata[63:32]  = wdata; req_wstrb[7:4]   = lane_strb; exp128[63:32]  = exp_val; end
      2'd2: begin req_wdata[95:64]  = wdata; req_wstrb[11:8]  = lane_strb; exp128[95:64]  = exp_val; end
      default: begin req_wdata[127:96] = wdata; req_wstrb[15:12] = lane_strb; exp128[127:96] = exp_val; end
    endcase
    if (wr) exp128 = '0;
    host_chr_vld = push_en;
    host_chr     = push_c;
    sb.push_back(exp128);
    @(posedge clk); #1;
    req_vld      = 1'b0;
    host_chr_vld = 1'b0;
    checkOutput("rsp_vld_latency", {127'h0, rsp_vld}, 128'h1);
    checkOutput("req_rdy_in_resp", {127'h0, req_rdy}, 128'h0);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp_val);
    applyStimulus(1'b0, addr, 32'h0, 4'h0, exp_val, 1'b0, 8'h00);
  endtask

  task automatic wr_ctrl(input logic [31:0] val);
    applyStimulus(1'b1, A_CTRL, val, 4'hF, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic push_chr(input logic [7:0] c);
    host_chr_vld = 1'b1;
    host_chr     = c;
    @(posedge clk); #1;
    host_chr_vld = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_b && rsp_vld) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_rsp: got %h expected no response", rsp_rdata);
      end else begin
        checkOutput("rsp_rdata", rsp_rdata, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_b = 1'b0; host_chr_vld = 1'b0; host_chr = '0;
    req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #2;
    checkOutput("reset_rsp_vld", {127'h0, rsp_vld}, 128'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 128'h0);
    checkOutput("reset_irq", {127'h0, irq}, 128'h0);
    checkOutput("reset_req_rdy", {127'h0, req_rdy}, 128'h1);
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    checkOutput("reset_host_rdy", {127'h0, host_chr_rdy}, 128'h1);

    // Basic push / status / pop sequence; STATUS lands in lane 1.
    push_chr("A"); push_chr("B"); push_chr("C");
    rd(A_STAT, 32'h0000_0003);
    rd(A_DATA, 32'h8000_0041);
    rd(A_DATA, 32'h8000_0042);
    rd(A_DATA, 32'h8000_0043);
    rd(A_DATA, 32'h0000_0000);
    rd(A_STAT, 32'h0001_0000);

    // Reserved offset, out-of-window read, and write to DATA have no effect.
    rd(A_RSVD, 32'h0);
    push_chr("X");
    rd(BASE + 32'h10, 32'h0);
    rd(A_STAT, 32'h0000_0001);
    rd(A_DATA, 32'h8000_0058);
    push_chr("Y");
    applyStimulus(1'b1, A_DATA, 32'h0, 4'hF, 32'h0, 1'b0, 8'h00);
    rd(A_STAT, 32'h0000_0001);
    rd(A_DATA, 32'h8000_0059);
    applyStimulus(1'b1, BASE + 32'h18, 32'h4, 4'hF, 32'h0, 1'b0, 8'h00);
    rd(A_CTRL, 32'h0);
    applyStimulus(1'b1, A_CTRL, 32'h4, 4'h7, 32'h0, 1'b0, 8'h00);
    rd(A_CTRL, 32'h0);

    // Fill past full: overflow, then clear it, then flush.
    for (int i = 0; i < 17; i++) begin
      checkOutput("host_rdy_fill", {127'h0, host_chr_rdy}, (i < 16) ? 128'h1 : 128'h0);
      push_chr(8'h61 + 8'(i));
    end
    rd(A_STAT, 32'h0006_0010);
    wr_ctrl(32'h2);
    rd(A_STAT, 32'h0002_0010);
    rd(A_CTRL, 32'h0);
    wr_ctrl(32'h1);
    rd(A_STAT, 32'h0001_0000);

    // Interrupt follows enable and occupancy.
    wr_ctrl(32'h4);
    rd(A_CTRL, 32'h0000_0004);
    checkOutput("irq_empty", {127'h0, irq}, 128'h0);
    push_chr("K");
    @(posedge clk); #1;
    checkOutput("irq_after_push", {127'h0, irq}, 128'h1);
    rd(A_DATA, 32'h8000_004B);
    checkOutput("irq_after_pop", {127'h0, irq}, 128'h0);

    // Push and pop in the same cycle.
    push_chr("P"); push_chr("Q");
    applyStimulus(1'b0, A_DATA, 32'h0, 4'h0, 32'h8000_0050, 1'b1, "R");
    rd(A_STAT, 32'h0000_0002);
    rd(A_DATA, 32'h8000_0051);
    rd(A_DATA, 32'h8000_0052);
    rd(A_STAT, 32'h0001_0000);

    // On a full FIFO the pop does not admit the same-cycle push.
    for (int i = 0; i < 16; i++) push_chr(8'h30 + 8'(i));
    applyStimulus(1'b0, A_DATA, 32'h0, 4'h0, 32'h8000_0030, 1'b1, "S");
    rd(A_STAT, 32'h0004_000F);
    push_chr("T");
    // Clear-overflow racing a new overflow leaves it set.
    applyStimulus(1'b1, A_CTRL, 32'h2, 4'hF, 32'h0, 1'b1, "U");
    rd(A_STAT, 32'h0006_0010);
    wr_ctrl(32'h3);
    rd(A_STAT, 32'h0001_0000);

    // Flush beats a same-cycle push.
    for (int i = 0; i < 5; i++) push_chr(8'h40 + 8'(i));
    rd(A_STAT, 32'h0000_0005);
    applyStimulus(1'b1, A_CTRL, 32'h1, 4'hF, 32'h0, 1'b1, "V");
    rd(A_STAT, 32'h0001_0000);

    // Reset pulse during RESP.
    wr_ctrl(32'h4);
    push_chr("M"); push_chr("N");
    @(posedge clk); #1;
    checkOutput("irq_before_reset", {127'h0, irq}, 128'h1);
    req_vld = 1'b1; req_wr = 1'b0; req_addr = A_DATA; req_wstrb = '0; req_wdata = '0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    rst_b = 1'b0;
    #1;
    checkOutput("midrst_rsp_vld", {127'h0, rsp_vld}, 128'h0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 128'h0);
    checkOutput("midrst_irq", {127'h0, irq}, 128'h0);
    checkOutput("midrst_req_rdy", {127'h0, req_rdy}, 128'h1);
    checkOutput("midrst_host_rdy", {127'h0, host_chr_rdy}, 128'h1);
    @(posedge clk); #1;
    rst_b = 1'b1;
    rd(A_STAT, 32'h0001_0000);
    rd(A_CTRL, 32'h0);

`ifdef CONSOLE_RX_MBOX_ECHO_EN
    push_chr("Z");
    sb.push_back({96'h0, 32'h8000_005A});
    req_vld = 1'b1; req_wr = 1'b0; req_addr = A_DATA;
    @(posedge clk); #1;
    req_vld = 1'b0;
    checkOutput("echo_vld", {127'h0, echo_vld}, 128'h1);
    checkOutput("echo_chr", {120'h0, echo_chr}, 128'h5A);
    @(posedge clk); #1;
    checkOutput("echo_vld_pulse", {127'h0, echo_vld}, 128'h0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_drained", 128'(sb.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
